// File: rtl/frog_pkg.sv
// Shared types and constants for the Frogger round sequencer.
package frog_pkg;

  typedef enum logic [2:0] {IDLE, PLAY, HIT, WIN, OVER} frog_state_t;

  localparam logic [2:0] SPAWN_ROW = 3'd0;
  localparam logic [2:0] SPAWN_COL = 3'd3;

  typedef logic [7:0][7:0] plane_t;

  function automatic plane_t onehot(input logic [2:0] row, input logic [2:0] col);
    plane_t p;
    p = '0;
    p[row][col] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/frog_pos.sv
// Frog position: row/col registers with saturating moves, spawn load and hold,
// plus a registered one-hot plane so exactly one bit is ever set.
module frog_pos
  import frog_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_spawn,
  input  logic       move_en,
  input  logic       u,
  input  logic       d,
  input  logic       l,
  input  logic       r,
  output logic [2:0] row,
  output logic [2:0] col,
  output plane_t     frog
);

  logic [2:0] row_n, col_n;

  // U is selected first even at row 7, where it deliberately does not move.
  always_comb begin
    row_n = row;
    col_n = col;
    if (load_spawn) begin
      row_n = SPAWN_ROW;
      col_n = SPAWN_COL;
    end else if (move_en) begin
      if (u) begin
        if (row != 3'd7) row_n = row + 3'd1;
      end else if (d) begin
        if (row != 3'd0) row_n = row - 3'd1;
      end else if (l) begin
        if (col != 3'd0) col_n = col - 3'd1;
      end else if (r) begin
        if (col != 3'd7) col_n = col + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row  <= SPAWN_ROW;
      col  <= SPAWN_COL;
      frog <= onehot(SPAWN_ROW, SPAWN_COL);
    end else begin
      row  <= row_n;
      col  <= col_n;
      frog <= onehot(row_n, col_n);
    end
  end

endmodule

// File: rtl/frog_game_ctrl.sv
// Frogger round sequencer: FSM, hit/win timer, lives and score.
// Optional high-score register enabled by defining FROG_HISCORE_EN.
module frog_game_ctrl
  import frog_pkg::*;
#(
  parameter int unsigned LIVES      = 3,
  parameter int unsigned HIT_CYCLES = 8,
  parameter int unsigned WIN_CYCLES = 8,
  parameter int unsigned SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               U,
  input  logic               D,
  input  logic               L,
  input  logic               R,
  input  logic               crashed,
  input  logic               survived,
  output plane_t             frog,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               flash,
  output logic               game_over
`ifdef FROG_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  localparam int unsigned TMAX = (HIT_CYCLES > WIN_CYCLES) ? HIT_CYCLES : WIN_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HIT_T      = TW'(HIT_CYCLES - 1);
  localparam logic [TW-1:0] WIN_T      = TW'(WIN_CYCLES - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  frog_state_t        state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [2:0]         lives_n;
  logic [SCORE_W-1:0] score_n;
  logic               load_spawn, move_en;
  logic [2:0]         row, col;

  frog_pos u_pos (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_spawn (load_spawn),
    .move_en    (move_en),
    .u          (U),
    .d          (D),
    .l          (L),
    .r          (R),
    .row        (row),
    .col        (col),
    .frog       (frog)
  );

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    lives_n    = lives;
    score_n    = score;
    load_spawn = 1'b0;
    move_en    = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n    = PLAY;
          lives_n    = LIVES_INIT;
          score_n    = '0;
          load_spawn = 1'b1;
        end
      end
      PLAY: begin
        if (crashed) begin
          lives_n = lives - 3'd1;
          timer_n = HIT_T;
          state_n = HIT;
        end else if (survived) begin
          score_n = (score == '1) ? score : score + SCORE_W'(1);
          timer_n = WIN_T;
          state_n = WIN;
        end else begin
          move_en = 1'b1;
        end
      end
      HIT: begin
        if (timer == '0) begin
          if (lives == 3'd0) begin
            state_n = OVER;
          end else begin
            state_n    = PLAY;
            load_spawn = 1'b1;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      WIN: begin
        if (timer == '0) begin
          state_n    = PLAY;
          load_spawn = 1'b1;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      lives     <= LIVES_INIT;
      score     <= '0;
      playing   <= 1'b0;
      flash     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      lives     <= lives_n;
      score     <= score_n;
      playing   <= (state_n == PLAY);
      flash     <= (state_n == HIT);
      game_over <= (state_n == OVER);
    end
  end

`ifdef FROG_HISCORE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiscore <= '0;
    end else if (state_n == OVER && state != OVER && score > hiscore) begin
      hiscore <= score;
    end
  end
`endif

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: vector table plus multi-cycle sequences.
module tb_frog_game_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic start, u, d, l, r, crashed, survived;
  logic [7:0][7:0] frog;
  logic [2:0] lives;
  logic [3:0] score;
  logic playing, flash, game_over;
`ifdef FROG_HISCORE_EN
  logic [3:0] hiscore;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frog_game_ctrl #(
    .LIVES      (3),
    .HIT_CYCLES (8),
    .WIN_CYCLES (8),
    .SCORE_W    (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .U         (u),
    .D         (d),
    .L         (l),
    .R         (r),
    .crashed   (crashed),
    .survived  (survived),
    .frog      (frog),
    .lives     (lives),
    .score     (score),
    .playing   (playing),
    .flash     (flash),
    .game_over (game_over)
`ifdef FROG_HISCORE_EN
    ,
    .hiscore   (hiscore)
`endif
  );

  typedef struct {
    logic st, u, d, l, r, cr, sv;
    int   row, col, lives, score, pl, fl, ov;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int st, input int uu, input int dd, input int ll,
                              input int rr, input int cr, input int sv, input int row,
                              input int col, input int lv, input int sc, input int pl,
                              input int fl, input int ov);
    vec_t v;
    v.st = st[0]; v.u = uu[0]; v.d = dd[0]; v.l = ll[0]; v.r = rr[0];
    v.cr = cr[0]; v.sv = sv[0];
    v.row = row; v.col = col; v.lives = lv; v.score = sc;
    v.pl = pl; v.fl = fl; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int row, input int col, input int lv,
                             input int sc, input int pl, input int fl, input int ov);
    logic [7:0][7:0] e;
    e = '0;
    e[row][col] = 1'b1;
    chk({name, ".frog"}, 64'(frog), 64'(e));
    chk({name, ".lives"}, 64'(lives), 64'(lv));
    chk({name, ".score"}, 64'(score), 64'(sc));
    chk({name, ".playing"}, 64'(playing), 64'(pl));
    chk({name, ".flash"}, 64'(flash), 64'(fl));
    chk({name, ".game_over"}, 64'(game_over), 64'(ov));
  endtask

  task automatic step(input logic st, input logic uu, input logic dd, input logic ll,
                      input logic rr, input logic cr, input logic sv);
    start = st; u = uu; d = dd; l = ll; r = rr; crashed = cr; survived = sv;
    @(posedge clk);
    #1;
    start = 0; u = 0; d = 0; l = 0; r = 0; crashed = 0; survived = 0;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Walk from spawn to the goal, survive, sit through the win display.
  task automatic do_win(input int exp_score, input int lv);
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    check_state($sformatf("win%0d", exp_score), 7, 3, lv, exp_score, 0, 0, 0);
    for (int k = 0; k < 7; k++) idle_step();
    idle_step();
    check_state($sformatf("win%0d_respawn", exp_score), 0, 3, lv, exp_score, 1, 0, 0);
  endtask

  // Crash at spawn and sit through the hit period.
  task automatic do_crash();
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) idle_step();
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; u = 0; d = 0; l = 0; r = 0; crashed = 0; survived = 0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 3, 3, 0, 0, 0, 0);
`ifdef FROG_HISCORE_EN
    chk("reset.hiscore", 64'(hiscore), 64'd0);
`endif
    reset_n = 1'b1;

    //               st u d l r cr sv row col lv sc pl fl ov
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 3, 3, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 4, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 5, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 4, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 4, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 4, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 2, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0));

    foreach (vq[i]) begin
      step(vq[i].st, vq[i].u, vq[i].d, vq[i].l, vq[i].r, vq[i].cr, vq[i].sv);
      check_state($sformatf("vec%0d", i), vq[i].row, vq[i].col, vq[i].lives,
                  vq[i].score, vq[i].pl, vq[i].fl, vq[i].ov);
    end

    // Remainder of the 8-cycle hit period, then respawn.
    for (int k = 0; k < 6; k++) begin
      idle_step();
      check_state($sformatf("hit_hold%0d", k), 1, 0, 2, 0, 0, 1, 0);
    end
    idle_step();
    check_state("hit_respawn", 0, 3, 2, 0, 1, 0, 0);

    // Walk to the goal; U at row 7 without survived does not move.
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      check_state($sformatf("up%0d", k), k, 3, 2, 0, 1, 0, 0);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    check_state("up_sat", 7, 3, 2, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    check_state("win_enter", 7, 3, 2, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 1, 1, 0, 1, 1);
      check_state($sformatf("win_hold%0d", k), 7, 3, 2, 1, 0, 0, 0);
    end
    idle_step();
    check_state("win_respawn", 0, 3, 2, 1, 1, 0, 0);

    // crashed beats survived beats moves on the same edge.
    step(0, 0, 0, 1, 0, 1, 1);
    check_state("prio_hit", 0, 3, 1, 1, 0, 1, 0);
    for (int k = 0; k < 7; k++) idle_step();
    check_state("prio_hold_end", 0, 3, 1, 1, 0, 1, 0);
    idle_step();
    check_state("prio_respawn", 0, 3, 1, 1, 1, 0, 0);

    // Last life: frog stays at crash square into OVER.
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_state("last_hit", 0, 4, 0, 1, 0, 1, 0);
    for (int k = 0; k < 7; k++) idle_step();
    idle_step();
    check_state("over", 0, 4, 0, 1, 0, 0, 1);
`ifdef FROG_HISCORE_EN
    chk("over.hiscore", 64'(hiscore), 64'd1);
`endif
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1);
    check_state("over_idle", 0, 4, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    check_state("restart", 0, 3, 3, 0, 1, 0, 0);
`ifdef FROG_HISCORE_EN
    chk("restart.hiscore", 64'(hiscore), 64'd1);
`endif

    // Score saturation at 15.
    for (int w = 1; w <= 16; w++) do_win((w > 15) ? 15 : w, 3);
    do_crash();
    do_crash();
    do_crash();
    check_state("sat_over", 0, 3, 0, 15, 0, 0, 1);
`ifdef FROG_HISCORE_EN
    chk("sat_over.hiscore", 64'(hiscore), 64'd15);
`endif

    // Asynchronous reset in the middle of HIT.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_state("pre_reset_hit", 0, 3, 2, 0, 0, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("async_reset", 0, 3, 3, 0, 0, 0, 0);
`ifdef FROG_HISCORE_EN
    chk("async_reset.hiscore", 64'(hiscore), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    check_state("post_reset_start", 0, 3, 3, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
